// File: rtl/axilite_uart_tx_feeder.sv
// axilite_uart_tx_feeder: byte FIFO drained into an AXI-lite UART by polling STATUS then writing TXDATA.
// Optional TX_FEEDER_ERR_CNT_EN adds err_count_o and retries the status read on an rresp error.
module axilite_uart_tx_feeder #(
  parameter logic [31:0] UART_BASE_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH     = 16
) (
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic [7:0]                    s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic [31:0]                   m_axilite_awaddr,
  output logic [2:0]                    m_axilite_awprot,
  output logic                          m_axilite_awvalid,
  input  logic                          m_axilite_awready,
  output logic [31:0]                   m_axilite_wdata,
  output logic [3:0]                    m_axilite_wstrb,
  output logic                          m_axilite_wvalid,
  input  logic                          m_axilite_wready,
  input  logic [1:0]                    m_axilite_bresp,
  input  logic                          m_axilite_bvalid,
  output logic                          m_axilite_bready,
  output logic [31:0]                   m_axilite_araddr,
  output logic [2:0]                    m_axilite_arprot,
  output logic                          m_axilite_arvalid,
  input  logic                          m_axilite_arready,
  input  logic [31:0]                   m_axilite_rdata,
  input  logic [1:0]                    m_axilite_rresp,
  input  logic                          m_axilite_rvalid,
  output logic                          m_axilite_rready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          busy_o
`ifdef TX_FEEDER_ERR_CNT_EN
  ,
  output logic [7:0]                    err_count_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, RD_STAT, WAIT_R, WR_TX, WAIT_B} state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_aw_done, r_w_done;
  logic          w_push, w_pop, w_aw_ok, w_w_ok, w_rerr, w_unused;
  assign s_ready_o    = r_count != (AW+1)'(FIFO_DEPTH);
  assign fifo_count_o = r_count;
  assign busy_o       = (r_state != IDLE) || (r_count != '0);
  assign w_push       = s_valid_i && s_ready_o;
  assign w_pop        = (r_state == WAIT_B) && m_axilite_bvalid;
  assign w_aw_ok      = r_aw_done || m_axilite_awready;
  assign w_w_ok       = r_w_done || m_axilite_wready;
`ifdef TX_FEEDER_ERR_CNT_EN
  logic [7:0] r_err;
  logic       w_err;
  assign w_rerr      = m_axilite_rresp != 2'b00;
  assign w_err       = (w_pop && m_axilite_bresp != 2'b00) || ((r_state == WAIT_R) && m_axilite_rvalid && w_rerr);
  assign err_count_o = r_err;
  assign w_unused    = ^{m_axilite_rdata[31:4], m_axilite_rdata[2:0]};
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) r_err <= '0;
    else if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
`else
  assign w_rerr   = 1'b0;
  assign w_unused = ^{m_axilite_rdata[31:4], m_axilite_rdata[2:0], m_axilite_bresp, m_axilite_rresp};
`endif
  always_ff @(posedge clock_i)
    if (w_push) r_mem[r_wr_ptr] <= s_data_i;
  // pointers are AW bits wide, so increment wraps modulo FIFO_DEPTH
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // per-channel acceptance flags let AW and W complete in different cycles
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      r_state   <= IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aw_done <= (r_state == WR_TX) && (w_next == WR_TX) && w_aw_ok;
      r_w_done  <= (r_state == WR_TX) && (w_next == WR_TX) && w_w_ok;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (r_count != '0) ? RD_STAT : IDLE;
      RD_STAT: w_next = m_axilite_arready ? WAIT_R : RD_STAT;
      WAIT_R:  w_next = !m_axilite_rvalid ? WAIT_R : (m_axilite_rdata[3] || w_rerr) ? RD_STAT : WR_TX;
      WR_TX:   w_next = (w_aw_ok && w_w_ok) ? WAIT_B : WR_TX;
      WAIT_B:  w_next = m_axilite_bvalid ? IDLE : WAIT_B;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    m_axilite_arvalid = r_state == RD_STAT;
    m_axilite_araddr  = m_axilite_arvalid ? UART_BASE_ADDR + 32'h8 : 32'h0;
    m_axilite_arprot  = 3'b000;
    m_axilite_rready  = r_state == WAIT_R;
    m_axilite_awvalid = (r_state == WR_TX) && !r_aw_done;
    m_axilite_wvalid  = (r_state == WR_TX) && !r_w_done;
    m_axilite_awaddr  = (r_state == WR_TX) ? UART_BASE_ADDR + 32'h4 : 32'h0;
    m_axilite_awprot  = 3'b000;
    m_axilite_wdata   = (r_state == WR_TX) ? {24'h0, r_mem[r_rd_ptr]} : 32'h0;
    m_axilite_wstrb   = (r_state == WR_TX) ? 4'b0001 : 4'b0000;
    m_axilite_bready  = r_state == WAIT_B;
  end
endmodule

// File: tb/tb_axilite_uart_tx_feeder.sv
// tb_axilite_uart_tx_feeder: directed bench for the AXI-lite UART TX feeder with a reactive slave.
module tb_axilite_uart_tx_feeder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic s_valid = 1'b0, s_ready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready, bvalid, rvalid;
  logic awready = 1'b1, wready = 1'b1, arready = 1'b1, b_en = 1'b1, bresp_err = 1'b0;
  logic [1:0] bresp, rresp;
  logic [4:0] fcount;
  logic busy;
  int checks = 0, failures = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, full_until = 0, rerr_until = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0] last_wstrb = '0;
  logic [7:0] wr_q[$];
`ifdef TX_FEEDER_ERR_CNT_EN
  logic [7:0] err_count;
`endif
  always #5 clk = ~clk;
  assign rvalid = rready;
  assign bvalid = bready && b_en;
  assign rdata  = (r_cnt < full_until) ? 32'h8 : 32'h0;
  assign rresp  = (r_cnt < rerr_until) ? 2'b10 : 2'b00;
  assign bresp  = bresp_err ? 2'b10 : 2'b00;
  axilite_uart_tx_feeder #(.UART_BASE_ADDR(32'h0000_0000), .FIFO_DEPTH(16)) dut (
    .clock_i(clk), .reset_ni(rst_n), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_axilite_awaddr(awaddr), .m_axilite_awprot(awprot), .m_axilite_awvalid(awvalid), .m_axilite_awready(awready),
    .m_axilite_wdata(wdata), .m_axilite_wstrb(wstrb), .m_axilite_wvalid(wvalid), .m_axilite_wready(wready),
    .m_axilite_bresp(bresp), .m_axilite_bvalid(bvalid), .m_axilite_bready(bready),
    .m_axilite_araddr(araddr), .m_axilite_arprot(arprot), .m_axilite_arvalid(arvalid), .m_axilite_arready(arready),
    .m_axilite_rdata(rdata), .m_axilite_rresp(rresp), .m_axilite_rvalid(rvalid), .m_axilite_rready(rready),
    .fifo_count_o(fcount), .busy_o(busy)
`ifdef TX_FEEDER_ERR_CNT_EN
    , .err_count_o(err_count)
`endif
  );
  always @(posedge clk) begin
    if (arvalid && arready) begin ar_cnt <= ar_cnt + 1; last_araddr <= araddr; end
    if (rvalid && rready) r_cnt <= r_cnt + 1;
    if (awvalid && awready) begin aw_cnt <= aw_cnt + 1; last_awaddr <= awaddr; end
    if (wvalid && wready) begin w_cnt <= w_cnt + 1; last_wdata <= wdata; last_wstrb <= wstrb; wr_q.push_back(wdata[7:0]); end
    if (bvalid && bready) b_cnt <= b_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_idle(input int maxc, output int n);
    n = 0;
    while (busy && n < maxc) begin @(negedge clk); n++; end
    check("idle_timeout", {31'b0, busy}, 32'h0);
  endtask
  task automatic push(input logic [7:0] b);
    int n;
    logic acc;
    n = 0;
    s_data = b;
    s_valid = 1'b1;
    do begin acc = s_ready; @(negedge clk); n++; end while (!acc && n < 500);
    s_valid = 1'b0;
    if (!acc) check("push_timeout", 32'h0, 32'h1);
  endtask
  initial begin
    int n, ar0, aw0, w0, b0, q0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", {31'b0, s_ready}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_count", {27'b0, fcount}, 32'h0);
    check("rst_valids", {27'b0, arvalid, awvalid, wvalid, bready, rready}, 32'h0);
    check("rst_addr_data", araddr | awaddr | wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    // single byte, zero-wait slave
    push(8'h41);
    wait_idle(100, n);
    check("t1_cycles", n, 5);
    check("t1_ar_cnt", ar_cnt, 1);
    check("t1_araddr", last_araddr, 32'h8);
    check("t1_aw_cnt", aw_cnt, 1);
    check("t1_awaddr", last_awaddr, 32'h4);
    check("t1_wdata", last_wdata, 32'h41);
    check("t1_wstrb", {28'b0, last_wstrb}, 32'h1);
    check("t1_count", {27'b0, fcount}, 32'h0);
    check("t1_prot", {26'b0, awprot, arprot}, 32'h0);
    // UART reports TX full three times
    ar0 = ar_cnt; aw0 = aw_cnt; q0 = wr_q.size();
    full_until = r_cnt + 3;
    push(8'h55);
    wait_idle(200, n);
    check("t2_ar_cnt", ar_cnt - ar0, 4);
    check("t2_aw_cnt", aw_cnt - aw0, 1);
    check("t2_byte", {24'b0, wr_q[q0]}, 32'h55);
    // fill FIFO while AW is stalled
    awready = 1'b0; q0 = wr_q.size();
    for (int i = 0; i < 17; i++) begin
      s_data = 8'(8'h10 + i); s_valid = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("t3_s_ready", {31'b0, s_ready}, 32'h0);
    check("t3_count", {27'b0, fcount}, 32'd16);
    check("t3_aw_held", {30'b0, awvalid, wvalid}, 32'h2);
    awready = 1'b1;
    wait_idle(500, n);
    check("t3_nwritten", wr_q.size() - q0, 16);
    for (int i = 0; i < 16; i++) check("t3_order", {24'b0, wr_q[q0 + i]}, 32'h10 + i);
    check("t3_count_end", {27'b0, fcount}, 32'h0);
    // AW accepted well before W
    wready = 1'b0; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    push(8'h77);
    n = 0;
    while (!wvalid && n < 50) begin @(negedge clk); n++; end
    check("t4_both_valid", {30'b0, awvalid, wvalid}, 32'h3);
    @(negedge clk);
    check("t4_aw_dropped", {30'b0, awvalid, wvalid}, 32'h1);
    repeat (2) @(negedge clk);
    check("t4_w_held", {31'b0, wvalid}, 32'h1);
    check("t4_wdata", wdata, 32'h77);
    wready = 1'b1;
    wait_idle(100, n);
    check("t4_aw_cnt", aw_cnt - aw0, 1);
    check("t4_w_cnt", w_cnt - w0, 1);
    check("t4_b_cnt", b_cnt - b0, 1);
    check("t4_count", {27'b0, fcount}, 32'h0);
    // reset while waiting for B with 5 bytes queued
    b_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
    n = 0;
    while (!bready && n < 100) begin @(negedge clk); n++; end
    check("t5_in_wait_b", {31'b0, bready}, 32'h1);
    check("t5_queued", {27'b0, fcount}, 32'd5);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valids", {27'b0, arvalid, awvalid, wvalid, bready, rready}, 32'h0);
    check("t5_rst_count", {27'b0, fcount}, 32'h0);
    check("t5_rst_flags", {30'b0, s_ready, busy}, 32'h2);
    check("t5_rst_addr_data", araddr | awaddr | wdata, 32'h0);
    b_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ar0 = ar_cnt; aw0 = aw_cnt;
    repeat (20) @(negedge clk);
    check("t5_no_traffic", (ar_cnt - ar0) + (aw_cnt - aw0), 0);
    check("t5_idle", {31'b0, busy}, 32'h0);
`ifdef TX_FEEDER_ERR_CNT_EN
    // rresp error forces a status re-read
    ar0 = ar_cnt;
    rerr_until = r_cnt + 1;
    push(8'h99);
    wait_idle(100, n);
    check("t6_ar_retry", ar_cnt - ar0, 2);
    check("t6_err_one", {24'b0, err_count}, 32'h1);
    bresp_err = 1'b1; b0 = b_cnt;
    for (int i = 0; i < 300; i++) push(8'(i));
    wait_idle(500, n);
    check("t6_b_cnt", b_cnt - b0, 300);
    check("t6_err_sat", {24'b0, err_count}, 32'hFF);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axilite_uart_tx_feeder.md
AXILITE_UART_TX_FEEDER -- requirements
Module: axilite_uart_tx_feeder

Interface
REQ-001 SHALL have parameter UART_BASE_ADDR, default 32'h0000_0000, base address of the downstream AXI-lite UART.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clock_i  input  1  single clock for all logic.
REQ-004 SHALL have port reset_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_data_i  input  8  byte to transmit.
REQ-006 SHALL have port s_valid_i  input  1  s_data_i valid.
REQ-007 SHALL have port s_ready_o  output  1  FIFO can accept a byte.
REQ-008 SHALL have ports m_axilite_aw{addr,prot,valid}  output  32/3/1, and m_axilite_awready  input  1: AXI-lite write address channel.
REQ-009 SHALL have ports m_axilite_w{data,strb,valid}  output  32/4/1, and m_axilite_wready  input  1: write data channel.
REQ-010 SHALL have ports m_axilite_bresp/bvalid  input  2/1, and m_axilite_bready  output  1: write response channel.
REQ-011 SHALL have ports m_axilite_ar{addr,prot,valid}  output  32/3/1, and m_axilite_arready  input  1: read address channel.
REQ-012 SHALL have ports m_axilite_r{data,resp,valid}  input  32/2/1, and m_axilite_rready  output  1: read data channel.
REQ-013 SHALL have port fifo_count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 SHALL have port busy_o  output  1  high when FSM not IDLE or FIFO not empty.

Function
REQ-015 SHALL push s_data_i into the FIFO on a cycle where s_valid_i && s_ready_o; s_ready_o SHALL be !full, combinational from registered state.
REQ-016 SHALL handle simultaneous push and pop in one cycle with count unchanged; a push is accepted when full only if a pop occurs in the same cycle: no (s_ready_o stays low when full).
REQ-017 SHALL use FSM states IDLE, RD_STAT, WAIT_R, WR_TX, WAIT_B.
REQ-018 IDLE -> RD_STAT when FIFO not empty.
REQ-019 RD_STAT: arvalid=1, araddr=UART_BASE_ADDR+32'h8; on arready -> WAIT_R.
REQ-020 WAIT_R: rready=1; on rvalid, if rdata[3] (TX FIFO full) -> RD_STAT, else -> WR_TX.
REQ-021 WR_TX: awvalid and wvalid asserted together, awaddr=UART_BASE_ADDR+32'h4, wdata={24'h0, FIFO head}, wstrb=4'b0001; each valid drops independently on its own ready; both accepted (same or different cycles) -> WAIT_B.
REQ-022 WAIT_B: bready=1; on bvalid pop FIFO head regardless of bresp -> IDLE.
REQ-023 SHALL hold every AXI valid high and its payload stable until the matching ready; awprot=arprot=3'b000 always.
REQ-024 Minimum cost per byte: 5 cycles with zero-wait-state slave (AR, R, AW/W, B, IDLE).
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH nor underflow.

Reset
REQ-026 On reset_ni low, asynchronously: FSM=IDLE, FIFO empty, fifo_count_o=0, all AXI valid/ready outputs 0, address/data outputs 0, busy_o=0, s_ready_o=1.
REQ-027 Reset mid-transaction SHALL abandon the transaction and discard FIFO contents.

Configuration
REQ-028 Macro TX_FEEDER_ERR_CNT_EN: when defined, SHALL add output err_count_o (8-bit) incrementing, saturating at 8'hFF, on each accepted bresp!=2'b00 or rresp!=2'b00, reset to 0; an rresp error SHALL route WAIT_R -> RD_STAT (retry).
REQ-029 Without TX_FEEDER_ERR_CNT_EN: no err_count_o port; responses SHALL be ignored and WAIT_R decides on rdata[3] alone.

Verification
REQ-030 Push 0x41, zero-wait slave, status 0 -> AR to 0x8, then AW 0x4/W 0x00000041 wstrb 0001; FIFO empty, busy_o=0 after 5 cycles.
REQ-031 Status rdata=32'h8 returned 3 times then 0 -> exactly 4 AR transactions, one write of the byte.
REQ-032 Push 17 bytes with awready tied low, FIFO_DEPTH=16 -> s_ready_o=0 after 16, fifo_count_o=16; release awready -> all 16 written in order.
REQ-033 awready 3 cycles before wready -> awvalid drops first, wvalid held; single B accepted, one pop.
REQ-034 reset_ni low during WAIT_B with 5 bytes queued -> all outputs per REQ-026 same cycle, no further AXI traffic.
REQ-035 With TX_FEEDER_ERR_CNT_EN, bresp=2'b10 on 300 writes -> err_count_o=8'hFF; rresp=2'b10 once -> status re-read.
